// File: rtl/seq_pkg.sv
// Shared types for the step scheduler: FSM state encoding and the 128-bit
// step word layout consumed by sequence_slice.
package seq_pkg;

  localparam int SEQ_W = 128;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    RUN      = 2'd2,
    DONE     = 2'd3
  } seq_state_t;

  // Step word field map, MSB first; rsv_* bits are ignored downstream.
  typedef struct packed {
    logic [13:0] rsv_127;
    logic [1:0]  ramp_down;   // [113:112]
    logic [9:0]  rsv_111;
    logic [3:0]  enable_pdm;  // [101:98]
    logic [1:0]  enable_dac;  // [97:96]
    logic [4:0]  rsv_95;
    logic [10:0] pdm3;        // [90:80]
    logic [4:0]  rsv_79;
    logic [10:0] pdm2;        // [74:64]
    logic [4:0]  rsv_63;
    logic [10:0] pdm1;        // [58:48]
    logic [4:0]  rsv_47;
    logic [10:0] pdm0;        // [42:32]
    logic [1:0]  resync;      // [31:30]
    logic [13:0] dac1;        // [29:16]
    logic [1:0]  rsv_15;
    logic [13:0] dac0;        // [13:0]
  } seq_word_t;

endpackage

// File: rtl/seq_step_scheduler_if.sv
// Step RAM read port shared by the scheduler (master) and the RAM (slave).
interface seq_step_scheduler_if #(
  parameter int ADDR_W = 14
);
  import seq_pkg::*;

  // Read contract: there is no valid/ready pair. The RAM registers the word
  // at mem_addr on every rising clk, so mem_rdata is valid one clk after
  // mem_addr is presented and the master must hold the address until then.
  logic [ADDR_W-1:0] mem_addr;
  logic [SEQ_W-1:0]  mem_rdata;

  modport master (output mem_addr, input  mem_rdata);
  modport slave  (input  mem_addr, output mem_rdata);
endinterface

// File: rtl/seq_step_prefetch.sv
// One-word lookahead buffer for the step RAM: owns the read address, the
// outstanding-fetch flag and the next step word with its address.
module seq_step_prefetch import seq_pkg::*; #(
  parameter int ADDR_W = 14
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 restart,
  input  logic                 advance,
  input  logic                 flush,
  input  logic [ADDR_W-1:0]    num_steps,
  seq_step_scheduler_if.master mem,
  output logic [SEQ_W-1:0]     next_buf,
  output logic [ADDR_W-1:0]    next_addr,
  output logic                 pending
);

  logic [ADDR_W-1:0] addr_q;

  // Address 0 is presented in the start cycle itself so the word is back in
  // time for the single PREFETCH clk.
  assign mem.mem_addr = restart ? '0 : addr_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q    <= '0;
      next_buf  <= '0;
      next_addr <= '0;
      pending   <= 1'b0;
    end else if (flush) begin
      pending <= 1'b0;
    end else if (restart) begin
      addr_q  <= '0;
      pending <= 1'b1;
    end else if (pending) begin
      next_buf  <= mem.mem_rdata;
      next_addr <= addr_q;
      addr_q    <= (addr_q == num_steps - ADDR_W'(1)) ? '0 : addr_q + ADDR_W'(1);
      pending   <= 1'b0;
    end else if (advance) begin
      pending <= 1'b1;
    end
  end

endmodule

// File: rtl/seq_step_scheduler.sv
// Plays stored 128-bit step words into seq_data, holding each for a set
// number of sample ticks and repeating the list a set number of times.
module seq_step_scheduler import seq_pkg::*; #(
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 sample_tick,
  input  logic                 cfg_enable,
  input  logic [ADDR_W-1:0]    cfg_num_steps,
  input  logic [CNT_W-1:0]     cfg_samples_per_step,
  input  logic [CNT_W-1:0]     cfg_num_reps,
  seq_step_scheduler_if.master mem,
  output logic [SEQ_W-1:0]     seq_data,
  output logic [ADDR_W-1:0]    step_index,
  output logic [CNT_W-1:0]     rep_count,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_error,
  output logic                 underrun,
  output seq_state_t           dbg_state
);

  seq_state_t        state_q;
  logic              en_q;
  logic              first_q;
  logic [ADDR_W-1:0] num_steps_q;
  logic [CNT_W-1:0]  spp_q;
  logic [CNT_W-1:0]  reps_q;
  logic [CNT_W-1:0]  sample_cnt;

  logic [SEQ_W-1:0]  next_buf;
  logic [ADDR_W-1:0] next_addr;
  logic              pending;

  logic start_edge, cfg_ok, restart, flush, tick_run, at_bound;
  logic underrun_hit, wrap_rep, finish, do_load;

  assign start_edge   = (state_q == IDLE) && cfg_enable && !en_q;
  assign cfg_ok       = (cfg_num_steps != '0) && (cfg_samples_per_step != '0);
  assign restart      = start_edge && cfg_ok;
  assign flush        = ((state_q == PREFETCH) || (state_q == RUN)) && !cfg_enable;
  assign tick_run     = (state_q == RUN) && cfg_enable && sample_tick;
  assign at_bound     = first_q || (sample_cnt == spp_q - CNT_W'(1));
  assign underrun_hit = tick_run && at_bound && pending;
  // A non-first load of address 0 starts a new repetition.
  assign wrap_rep     = !first_q && (next_addr == '0);
  assign finish       = tick_run && at_bound && !pending && wrap_rep &&
                        (reps_q != '0) && (rep_count == reps_q - CNT_W'(1));
  assign do_load      = tick_run && at_bound && !pending && !finish;

  assign dbg_state = state_q;

  seq_step_prefetch #(.ADDR_W(ADDR_W)) u_prefetch (
    .clk       (clk),
    .aresetn   (aresetn),
    .restart   (restart),
    .advance   (do_load),
    .flush     (flush),
    .num_steps (num_steps_q),
    .mem       (mem),
    .next_buf  (next_buf),
    .next_addr (next_addr),
    .pending   (pending)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      en_q        <= 1'b0;
      first_q     <= 1'b0;
      num_steps_q <= '0;
      spp_q       <= '0;
      reps_q      <= '0;
      sample_cnt  <= '0;
      seq_data    <= '0;
      step_index  <= '0;
      rep_count   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_error   <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      en_q <= cfg_enable;
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            num_steps_q <= cfg_num_steps;
            spp_q       <= cfg_samples_per_step;
            reps_q      <= cfg_num_reps;
            if (!cfg_ok) begin
              cfg_error <= 1'b1;
            end else begin
              cfg_error <= 1'b0;
              underrun  <= 1'b0;
              done      <= 1'b0;
              rep_count <= '0;
              busy      <= 1'b1;
              state_q   <= PREFETCH;
            end
          end
        end
        PREFETCH: begin
          if (!cfg_enable) begin
            state_q  <= IDLE;
            seq_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
          end else begin
            first_q <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (!cfg_enable) begin
            state_q  <= IDLE;
            seq_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
          end else if (underrun_hit) begin
            // Hold the current word and sample_cnt so the next tick retries.
            underrun <= 1'b1;
          end else if (finish) begin
            state_q   <= DONE;
            seq_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            rep_count <= rep_count + CNT_W'(1);
          end else if (do_load) begin
            seq_data   <= next_buf;
            step_index <= next_addr;
            sample_cnt <= '0;
            first_q    <= 1'b0;
            if (wrap_rep && (rep_count != '1)) rep_count <= rep_count + CNT_W'(1);
          end else if (sample_tick) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (!cfg_enable) begin
            state_q <= IDLE;
            done    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_step_scheduler.sv
// Self-checking bench for seq_step_scheduler against an arithmetic model of
// step playback (step = (ticks-1)/spp, address = step%steps, rep = step/steps).
module tb_seq_step_scheduler;
  import seq_pkg::*;

  localparam int ADDR_W = 14;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              aresetn;
  logic              sample_tick;
  logic              cfg_enable;
  logic [ADDR_W-1:0] cfg_num_steps;
  logic [CNT_W-1:0]  cfg_samples_per_step;
  logic [CNT_W-1:0]  cfg_num_reps;
  logic [127:0]      seq_data;
  logic [ADDR_W-1:0] step_index;
  logic [CNT_W-1:0]  rep_count;
  logic              busy, done, cfg_error, underrun;
  seq_state_t        dbg_state;

  logic [127:0] ram [16];
  int n_checks = 0;
  int n_fail   = 0;

  seq_step_scheduler_if #(.ADDR_W(ADDR_W)) mif ();

  seq_step_scheduler #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .aresetn              (aresetn),
    .sample_tick          (sample_tick),
    .cfg_enable           (cfg_enable),
    .cfg_num_steps        (cfg_num_steps),
    .cfg_samples_per_step (cfg_samples_per_step),
    .cfg_num_reps         (cfg_num_reps),
    .mem                  (mif),
    .seq_data             (seq_data),
    .step_index           (step_index),
    .rep_count            (rep_count),
    .busy                 (busy),
    .done                 (done),
    .cfg_error            (cfg_error),
    .underrun             (underrun),
    .dbg_state            (dbg_state)
  );

  // clock / reset / RAM model
  always #5 clk = ~clk;
  always @(posedge clk) mif.mem_rdata <= ram[mif.mem_addr[3:0]];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: expected outputs after n effective ticks since start
  function automatic void model(input int n, input int steps, input int spp, input int reps,
                                output logic [127:0] e_seq, output int e_rep, output bit e_done);
    int s, r, a;
    s = (n - 1) / spp;
    r = s / steps;
    a = s % steps;
    if (reps != 0 && r >= reps) begin
      e_seq = '0; e_rep = reps; e_done = 1'b1;
    end else begin
      e_seq = ram[a]; e_rep = r; e_done = 1'b0;
    end
  endfunction

  // driver tasks
  task automatic fill_ram_inc();
    for (int i = 0; i < 16; i++) ram[i] = 128'(i + 1);
  endtask

  task automatic fill_ram_random();
    for (int i = 0; i < 16; i++) ram[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic tick(input int gap);
    repeat (gap - 1) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic start_run(input int steps, input int spp, input int reps);
    @(negedge clk);
    cfg_enable           = 1'b0;
    cfg_num_steps        = ADDR_W'(steps);
    cfg_samples_per_step = CNT_W'(spp);
    cfg_num_reps         = CNT_W'(reps);
    @(negedge clk);
    cfg_enable = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic stop_run();
    @(negedge clk);
    cfg_enable = 1'b0;
    @(negedge clk);
  endtask

  // scenarios
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (seq_data !== '0) begin n_fail++; $display("FAIL reset_seq_data got %h want 0", seq_data); end
    n_checks++; if ({busy, done, cfg_error, underrun} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {busy, done, cfg_error, underrun}); end
    n_checks++; if (rep_count !== '0 || step_index !== '0) begin n_fail++; $display("FAIL reset_counts got rep %0d idx %0d want 0 0", rep_count, step_index); end
    n_checks++; if (mif.mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr got %0d want 0", mif.mem_addr); end
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d want %0d", dbg_state, IDLE); end
    aresetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_finite();
    logic [127:0] e_seq; int e_rep; bit e_done;
    fill_ram_inc();
    start_run(3, 2, 2);
    n_checks++; if (busy !== 1'b1 || dbg_state !== RUN) begin n_fail++; $display("FAIL fin_start got busy %b state %0d want 1 %0d", busy, dbg_state, RUN); end
    for (int k = 1; k <= 13; k++) begin
      tick(4);
      model(k, 3, 2, 2, e_seq, e_rep, e_done);
      n_checks++; if (seq_data !== e_seq) begin n_fail++; $display("FAIL fin_seq tick %0d got %h want %h", k, seq_data, e_seq); end
      n_checks++; if (rep_count !== CNT_W'(e_rep) || done !== e_done) begin n_fail++; $display("FAIL fin_rep tick %0d got %0d/%b want %0d/%b", k, rep_count, done, e_rep, e_done); end
    end
    n_checks++; if (dbg_state !== DONE || busy !== 1'b0 || rep_count !== 32'd2) begin n_fail++; $display("FAIL fin_end got state %0d busy %b rep %0d want %0d 0 2", dbg_state, busy, rep_count, DONE); end
    stop_run();
    n_checks++; if (done !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL fin_clear got done %b state %0d want 0 %0d", done, dbg_state, IDLE); end
  endtask

  task automatic test_random_finite();
    logic [127:0] e_seq; int e_rep; bit e_done;
    int steps, spp, reps, total;
    for (int it = 0; it < 4; it++) begin
      fill_ram_random();
      steps = $urandom_range(1, 6);
      spp   = $urandom_range(1, 3);
      reps  = $urandom_range(1, 3);
      total = steps * spp * reps + 2;
      start_run(steps, spp, reps);
      for (int k = 1; k <= total; k++) begin
        tick($urandom_range(2, 4));
        model(k, steps, spp, reps, e_seq, e_rep, e_done);
        n_checks++; if (seq_data !== e_seq) begin n_fail++; $display("FAIL rnd_seq it %0d tick %0d got %h want %h", it, k, seq_data, e_seq); end
        n_checks++; if (rep_count !== CNT_W'(e_rep) || done !== e_done || busy !== !e_done) begin n_fail++; $display("FAIL rnd_status it %0d tick %0d got rep %0d done %b busy %b want %0d %b %b", it, k, rep_count, done, busy, e_rep, e_done, !e_done); end
      end
      stop_run();
    end
  endtask

  task automatic test_infinite();
    logic [127:0] e_seq; int e_rep; bit e_done;
    int errs;
    errs = 0;
    fill_ram_random();
    start_run(2, 1, 0);
    for (int k = 1; k <= 1000; k++) begin
      tick(2);
      model(k, 2, 1, 0, e_seq, e_rep, e_done);
      n_checks++; if (seq_data !== e_seq || rep_count !== CNT_W'(e_rep)) begin
        n_fail++; errs++;
        if (errs < 5) $display("FAIL inf_tick %0d got %h/%0d want %h/%0d", k, seq_data, rep_count, e_seq, e_rep);
      end
    end
    n_checks++; if (rep_count !== 32'd499) begin n_fail++; $display("FAIL inf_rep_final got %0d want 499", rep_count); end
    n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL inf_status got busy %b done %b want 1 0", busy, done); end
    stop_run();
  endtask

  task automatic test_stop();
    fill_ram_inc();
    start_run(3, 2, 2);
    for (int k = 1; k <= 4; k++) tick(4);
    repeat (3) @(negedge clk);
    cfg_enable  = 1'b0;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    n_checks++; if (dbg_state !== IDLE || seq_data !== '0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL stop_outputs got state %0d seq %h busy %b done %b want %0d 0 0 0", dbg_state, seq_data, busy, done, IDLE); end
    n_checks++; if (rep_count !== '0 || step_index !== 14'd1) begin n_fail++; $display("FAIL stop_hold got rep %0d idx %0d want 0 1", rep_count, step_index); end
    start_run(3, 2, 2);
    n_checks++; if (rep_count !== '0 || busy !== 1'b1) begin n_fail++; $display("FAIL stop_restart got rep %0d busy %b want 0 1", rep_count, busy); end
    tick(3);
    n_checks++; if (seq_data !== 128'd1 || step_index !== '0) begin n_fail++; $display("FAIL stop_first got %h idx %0d want 1 0", seq_data, step_index); end
  endtask

  task automatic test_cfg_error();
    logic [ADDR_W-1:0] snap;
    stop_run();
    snap = mif.mem_addr;
    start_run(0, 2, 1);
    n_checks++; if (cfg_error !== 1'b1 || busy !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL err_steps got err %b busy %b state %0d want 1 0 %0d", cfg_error, busy, dbg_state, IDLE); end
    n_checks++; if (mif.mem_addr !== snap) begin n_fail++; $display("FAIL err_mem_addr got %0d want %0d", mif.mem_addr, snap); end
    start_run(3, 0, 1);
    n_checks++; if (cfg_error !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL err_spp got err %b busy %b want 1 0", cfg_error, busy); end
    start_run(3, 2, 1);
    n_checks++; if (cfg_error !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL err_clear got err %b busy %b want 0 1", cfg_error, busy); end
    stop_run();
  endtask

  task automatic test_underrun();
    fill_ram_random();
    start_run(4, 1, 0);
    tick(3);
    n_checks++; if (seq_data !== ram[0] || underrun !== 1'b0) begin n_fail++; $display("FAIL ur_first got %h ur %b want %h 0", seq_data, underrun, ram[0]); end
    tick(3);
    n_checks++; if (seq_data !== ram[1]) begin n_fail++; $display("FAIL ur_step1 got %h want %h", seq_data, ram[1]); end
    tick(1);
    n_checks++; if (seq_data !== ram[1] || underrun !== 1'b1 || step_index !== 14'd1) begin n_fail++; $display("FAIL ur_hold got %h ur %b idx %0d want %h 1 1", seq_data, underrun, step_index, ram[1]); end
    for (int k = 2; k <= 4; k++) begin
      tick(3);
      n_checks++; if (seq_data !== ram[k % 4] || step_index !== ADDR_W'(k % 4)) begin n_fail++; $display("FAIL ur_resume step %0d got %h idx %0d want %h", k, seq_data, step_index, ram[k % 4]); end
    end
    n_checks++; if (rep_count !== 32'd1 || underrun !== 1'b1) begin n_fail++; $display("FAIL ur_rep got %0d ur %b want 1 1", rep_count, underrun); end
    stop_run();
  endtask

  task automatic test_async_reset();
    fill_ram_random();
    start_run(3, 1, 0);
    for (int k = 0; k < 3; k++) tick(2);
    @(negedge clk);
    #2 aresetn = 1'b0;
    #1;
    n_checks++; if (seq_data !== '0 || busy !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL arst_now got seq %h busy %b state %0d want 0 0 %0d", seq_data, busy, dbg_state, IDLE); end
    n_checks++; if (rep_count !== '0 || step_index !== '0 || mif.mem_addr !== '0) begin n_fail++; $display("FAIL arst_counts got rep %0d idx %0d addr %0d want 0 0 0", rep_count, step_index, mif.mem_addr); end
    cfg_enable = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    for (int k = 0; k < 3; k++) tick(2);
    n_checks++; if (busy !== 1'b0 || seq_data !== '0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL arst_quiet got busy %b seq %h state %0d want 0 0 %0d", busy, seq_data, dbg_state, IDLE); end
    start_run(3, 1, 0);
    tick(2);
    n_checks++; if (seq_data !== ram[0] || busy !== 1'b1 || step_index !== '0) begin n_fail++; $display("FAIL arst_restart got %h busy %b idx %0d want %h 1 0", seq_data, busy, step_index, ram[0]); end
    stop_run();
  endtask

  initial begin
    aresetn              = 1'b0;
    sample_tick          = 1'b0;
    cfg_enable           = 1'b0;
    cfg_num_steps        = '0;
    cfg_samples_per_step = '0;
    cfg_num_reps         = '0;
    fill_ram_inc();
    test_reset();
    test_finite();
    test_random_finite();
    test_infinite();
    test_stop();
    test_cfg_error();
    test_underrun();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
